// File: rtl/rv_decode_pkg.sv
// Shared definitions for the RV32I decode stage.
//   - OPC_* : 7-bit major opcodes recognised by the decoder
//   - opclass_e : 4-bit instruction class reported to execute
//   - imm_type_e : which immediate format the instruction carries
//   - ctrl_t : per-instruction control produced by the opcode decode
//   - sext() : sign-extend the low 'width' bits of a 32-bit value
package rv_decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // OC_ILLEGAL is reported for unrecognised opcodes so execute never
  // mistakes an illegal word for a valid R-type.
  typedef enum logic [3:0] {
    OC_R       = 4'd0,
    OC_I_ALU   = 4'd1,
    OC_LOAD    = 4'd2,
    OC_STORE   = 4'd3,
    OC_BRANCH  = 4'd4,
    OC_JAL     = 4'd5,
    OC_JALR    = 4'd6,
    OC_LUI     = 4'd7,
    OC_AUIPC   = 4'd8,
    OC_SYSTEM  = 4'd9,
    OC_ILLEGAL = 4'd15
  } opclass_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    opclass_e  opclass;
    imm_type_e imm_type;
    logic      use_rs1;
    logic      use_rs2;
    logic      reg_write;
    logic      illegal;
  } ctrl_t;

  // Sign-extend the low 'width' bits (1..32) of val to 32 bits.
  function automatic logic [31:0] sext(input logic [31:0] val, input int unsigned width);
    logic signed [31:0] shifted;
    shifted = $signed(val << (32 - width));
    return $unsigned(shifted >>> (32 - width));
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file for the decode stage.
//   clk, rst            : clock, asynchronous active-high reset (clears all registers)
//   rd_addr_a/rd_data_a : combinational read port A
//   rd_addr_b/rd_data_b : combinational read port B
//   wr_en/wr_addr/wr_data : synchronous write port (writes to x0 ignored)
// Register x0 always reads zero. With BYPASS_EN=1 a write presented in the
// same cycle as a read of the same register is forwarded to the read port.
module reg_file #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int RA_W      = 5,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  input  logic [RA_W-1:0] rd_addr_b,
  output logic [XLEN-1:0] rd_data_b,
  input  logic            wr_en,
  input  logic [RA_W-1:0] wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_hit;

  assign wr_hit = wr_en && (wr_addr != '0);

  // Index 0 is reset and never written, so it stays zero and folds away.
  always_comb begin
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [XLEN-1:0] read_port(
    input logic [RA_W-1:0] addr,
    input logic [XLEN-1:0] stored,
    input logic            hit,
    input logic [RA_W-1:0] waddr,
    input logic [XLEN-1:0] wdata
  );
    if (addr == '0) begin
      return '0;
    end
    if (BYPASS_EN && hit && (waddr == addr)) begin
      return wdata;
    end
    return stored;
  endfunction

  assign rd_data_a = read_port(rd_addr_a, regs_q[rd_addr_a], wr_hit, wr_addr, wr_data);
  assign rd_data_b = read_port(rd_addr_b, regs_q[rd_addr_b], wr_hit, wr_addr, wr_data);

endmodule

// File: rtl/decode_stage.sv
// Pipelined RV32I decode stage between fetch and execute.
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready         : fetch handshake (instr, pc_in)
//   flush                     : discard the held bundle and any incoming instruction
//   wb_en/wb_addr/wb_data     : register-file write-back port
//   out_valid/out_ready       : execute handshake
//   pc_out, rs1_data, rs2_data, imm, rd, reg_write, opclass, illegal : decoded bundle
// Opcode decode, immediate generation and register reads are combinational
// from instr; the result is captured into one output register on accept.
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int RA_W      = 5,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [RA_W-1:0] rd,
  output logic            reg_write,
  output logic [3:0]      opclass,
  output logic            illegal
);

  // ---------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------
  ctrl_t ctrl;

  always_comb begin
    ctrl = '{opclass: OC_ILLEGAL, imm_type: IMM_NONE, use_rs1: 1'b0,
             use_rs2: 1'b0, reg_write: 1'b0, illegal: 1'b1};
    case (instr[6:0])
      OPC_OP: begin
        ctrl = '{OC_R, IMM_NONE, 1'b1, 1'b1, 1'b1, 1'b0};
      end
      OPC_OP_IMM: begin
        ctrl = '{OC_I_ALU, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0};
      end
      OPC_LOAD: begin
        ctrl = '{OC_LOAD, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0};
      end
      OPC_STORE: begin
        ctrl = '{OC_STORE, IMM_S, 1'b1, 1'b1, 1'b0, 1'b0};
      end
      OPC_BRANCH: begin
        ctrl = '{OC_BRANCH, IMM_B, 1'b1, 1'b1, 1'b0, 1'b0};
      end
      OPC_JAL: begin
        ctrl = '{OC_JAL, IMM_J, 1'b0, 1'b0, 1'b1, 1'b0};
      end
      OPC_JALR: begin
        ctrl = '{OC_JALR, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0};
      end
      OPC_LUI: begin
        ctrl = '{OC_LUI, IMM_U, 1'b0, 1'b0, 1'b1, 1'b0};
      end
      OPC_AUIPC: begin
        ctrl = '{OC_AUIPC, IMM_U, 1'b0, 1'b0, 1'b1, 1'b0};
      end
      // CSR instructions write rd and carry the CSR address as an I-immediate.
      OPC_SYSTEM: begin
        ctrl = '{OC_SYSTEM, IMM_I, 1'b1, 1'b0, 1'b1, 1'b0};
      end
      default: begin
      end
    endcase
  end

  // funct3/funct7 belong to execute; decode only classifies on the opcode.
  logic unused_funct3;
  assign unused_funct3 = ^instr[14:12];

  // ---------------------------------------------------------------------
  // Immediate generation (32-bit, then widened to XLEN)
  // ---------------------------------------------------------------------
  logic [31:0]     imm_raw;
  logic [XLEN-1:0] imm_ext;

  always_comb begin
    imm_raw = '0;
    case (ctrl.imm_type)
      IMM_I: imm_raw = sext({20'b0, instr[31:20]}, 12);
      IMM_S: imm_raw = sext({20'b0, instr[31:25], instr[11:7]}, 12);
      IMM_B: imm_raw = sext({19'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13);
      IMM_J: imm_raw = sext({11'b0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, 21);
      IMM_U: imm_raw = {instr[31:12], 12'b0};
      default: imm_raw = '0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm_raw));

  // ---------------------------------------------------------------------
  // Register file: unused ports are steered to x0 so they read zero.
  // ---------------------------------------------------------------------
  logic [RA_W-1:0] rs1_addr;
  logic [RA_W-1:0] rs2_addr;
  logic [XLEN-1:0] rf_rs1;
  logic [XLEN-1:0] rf_rs2;

  assign rs1_addr = ctrl.use_rs1 ? RA_W'(instr[19:15]) : '0;
  assign rs2_addr = ctrl.use_rs2 ? RA_W'(instr[24:20]) : '0;

  reg_file #(
    .XLEN      (XLEN),
    .NREG      (NREG),
    .RA_W      (RA_W),
    .BYPASS_EN (BYPASS_EN)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rs1_addr),
    .rd_data_a (rf_rs1),
    .rd_addr_b (rs2_addr),
    .rd_data_b (rf_rs2),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  // ---------------------------------------------------------------------
  // Output pipeline register with valid/ready handshake
  // ---------------------------------------------------------------------
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] pc_q,        pc_d;
  logic [XLEN-1:0] rs1_q,       rs1_d;
  logic [XLEN-1:0] rs2_q,       rs2_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic [RA_W-1:0] rd_q,        rd_d;
  logic            reg_write_q, reg_write_d;
  opclass_e        opclass_q,   opclass_d;
  logic            illegal_q,   illegal_d;
  logic            accept;

  assign in_ready = !out_valid_q || out_ready;
  // flush wins over a simultaneous accept.
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    opclass_d   = opclass_q;
    illegal_d   = illegal_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      pc_d        = pc_in;
      rs1_d       = rf_rs1;
      rs2_d       = rf_rs2;
      imm_d       = imm_ext;
      rd_d        = ctrl.reg_write ? RA_W'(instr[11:7]) : '0;
      reg_write_d = ctrl.reg_write;
      opclass_d   = ctrl.opclass;
      illegal_d   = ctrl.illegal;
    end else if (out_ready) begin
      // Pop without push: bundle fields keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      opclass_q   <= OC_R;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      opclass_q   <= opclass_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = pc_q;
  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
  assign imm       = imm_q;
  assign rd        = rd_q;
  assign reg_write = reg_write_q;
  assign opclass   = opclass_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a behavioural model (register array,
// arithmetic immediate extraction, valid flag) checked every cycle, plus
// hand-computed literal expectations for the directed vectors.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        reg_write;
  logic [3:0]  opclass;
  logic        illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREG(32), .RA_W(5), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
    .reg_write(reg_write), .opclass(opclass), .illegal(illegal)
  );

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic [3:0]  oc;
    logic        ill;
  } bundle_t;

  logic [31:0] m_rf [32];
  logic        m_valid;
  bundle_t     m_b;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (wb_en && wb_addr == idx) return wb_data;
    return m_rf[idx];
  endfunction

  function automatic bundle_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    logic [31:0] sx;
    bit r1, r2;
    b = '0;
    b.pc = pc;
    sx = {32{ins[31]}};
    r1 = 0;
    r2 = 0;
    case (ins[6:0])
      7'h33: begin b.oc = 0; b.rw = 1; r1 = 1; r2 = 1; end
      7'h13: begin b.oc = 1; b.rw = 1; r1 = 1; b.imm = (sx << 12) | (ins >> 20); end
      7'h03: begin b.oc = 2; b.rw = 1; r1 = 1; b.imm = (sx << 12) | (ins >> 20); end
      7'h23: begin
        b.oc = 3; r1 = 1; r2 = 1;
        b.imm = (sx << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
      end
      7'h63: begin
        b.oc = 4; r1 = 1; r2 = 1;
        b.imm = (sx << 12) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5)
              | (((ins >> 8) & 32'hF) << 1);
      end
      7'h6F: begin
        b.oc = 5; b.rw = 1;
        b.imm = (sx << 20) | (ins & 32'h000FF000) | (((ins >> 20) & 32'h1) << 11)
              | (((ins >> 21) & 32'h3FF) << 1);
      end
      7'h67: begin b.oc = 6; b.rw = 1; r1 = 1; b.imm = (sx << 12) | (ins >> 20); end
      7'h37: begin b.oc = 7; b.rw = 1; b.imm = ins & 32'hFFFFF000; end
      7'h17: begin b.oc = 8; b.rw = 1; b.imm = ins & 32'hFFFFF000; end
      7'h73: begin b.oc = 9; b.rw = 1; r1 = 1; b.imm = (sx << 12) | (ins >> 20); end
      default: begin b.oc = 15; b.ill = 1; end
    endcase
    b.rs1 = r1 ? m_read(ins[19:15]) : 32'h0;
    b.rs2 = r2 ? m_read(ins[24:20]) : 32'h0;
    b.rd  = b.rw ? ins[11:7] : 5'd0;
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_b = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else begin
      bit rdy;
      rdy = !m_valid || out_ready;
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin
        m_b = model_decode(instr, pc_in);
        m_valid = 1'b1;
      end else if (out_ready) m_valid = 1'b0;
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run_chk && !rst) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      if (m_valid) begin
        chk("pc_out", pc_out, m_b.pc);
        chk("rs1_data", rs1_data, m_b.rs1);
        chk("rs2_data", rs2_data, m_b.rs2);
        chk("imm", imm, m_b.imm);
        chk("rd", rd, m_b.rd);
        chk("reg_write", reg_write, m_b.rw);
        chk("opclass", opclass, m_b.oc);
        chk("illegal", illegal, m_b.ill);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    instr = ins;
    pc_in = pc;
  endtask

  logic [31:0] stream [4];

  initial begin
    stream[0] = 32'h00100313;  // addi x6,x0,1
    stream[1] = 32'h002081B3;  // add x3,x1,x2
    stream[2] = 32'h0020A023;  // sw x2,0(x1)
    stream[3] = 32'h00008067;  // jalr x0,0(x1)

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_imm", imm, 0);
    chk("rst_rd", rd, 0);
    rst = 1'b0;
    run_chk = 1'b1;

    // 1. Reset then read: add x3,x1,x2
    out_ready = 1'b1;
    push(32'h002081B3, 32'h100);
    step();
    $display("txn add x3,x1,x2 rs1=%h rs2=%h rd=%0d", rs1_data, rs2_data, rd);
    chk("t1_valid", out_valid, 1);
    chk("t1_rs1", rs1_data, 0);
    chk("t1_rs2", rs2_data, 0);
    chk("t1_rd", rd, 3);
    chk("t1_rw", reg_write, 1);
    chk("t1_opclass", opclass, 0);

    // 2. Bypass on x1 while accepting addi x5,x1,-1
    push(32'hFFF08293, 32'h104);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
    step();
    $display("txn addi x5,x1,-1 rs1=%h imm=%h rd=%0d", rs1_data, imm, rd);
    chk("t2_rs1_bypass", rs1_data, 32'h1234);
    chk("t2_imm", imm, 32'hFFFFFFFF);
    chk("t2_rd", rd, 5);

    // 3. Immediates (x2 <= 0x55 written alongside)
    push(32'hABCDE3B7, 32'h108);
    wb_addr = 5'd2; wb_data = 32'h55;
    step();
    wb_en = 1'b0;
    $display("txn lui imm=%h", imm);
    chk("t3_lui_imm", imm, 32'hABCDE000);
    chk("t3_lui_rd", rd, 7);
    push(32'hFE000EE3, 32'h10C);
    step();
    $display("txn beq imm=%h", imm);
    chk("t3_beq_imm", imm, 32'hFFFFFFFC);
    chk("t3_beq_rw", reg_write, 0);
    push(32'h001000EF, 32'h110);
    step();
    $display("txn jal imm=%h", imm);
    chk("t3_jal_imm", imm, 32'h00000800);
    chk("t3_jal_rd", rd, 1);

    // 4. Back-pressure on a bundle reading x1/x2; x1 rewritten during hold
    push(32'h002081B3, 32'h114);
    step();
    chk("t4_add_rs1", rs1_data, 32'h1234);
    chk("t4_add_rs2", rs2_data, 32'h55);
    out_ready = 1'b0;
    push(stream[0], 32'h118);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hAAAA;
    for (int k = 0; k < 3; k++) begin
      step();
      wb_en = 1'b0;
      $display("txn hold %0d in_ready=%b pc_out=%h rs1=%h", k, in_ready, pc_out, rs1_data);
      chk("t4_hold_in_ready", in_ready, 0);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_pc", pc_out, 32'h114);
      chk("t4_hold_rs1", rs1_data, 32'h1234);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(stream[k], 32'h118 + 32'(4 * k));
      step();
      $display("txn stream %0d pc_out=%h rs1=%h", k, pc_out, rs1_data);
      chk("t4_stream_pc", pc_out, 32'h118 + 32'(4 * k));
      chk("t4_stream_valid", out_valid, 1);
    end
    chk("t4_add_new_x1", rs1_data, 32'hAAAA);
    in_valid = 1'b0;
    step();
    $display("txn pop-only out_valid=%b pc_out=%h", out_valid, pc_out);
    chk("t4_pop_valid", out_valid, 0);
    chk("t4_pop_pc_kept", pc_out, 32'h124);

    // 5. x0 writes ignored, bypass never applies to x0
    push(32'h000001B3, 32'h200);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    step();
    wb_en = 1'b0;
    chk("t5_x0_same_cycle", rs1_data, 0);
    push(32'h000001B3, 32'h204);
    step();
    $display("txn x0 read rs1=%h rs2=%h", rs1_data, rs2_data);
    chk("t5_x0_rs1", rs1_data, 0);
    chk("t5_x0_rs2", rs2_data, 0);
    // flush while valid and accepting; RF write still lands
    push(32'h000481B3, 32'h208);
    flush = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    step();
    flush = 1'b0;
    wb_en = 1'b0;
    $display("txn flush out_valid=%b pc_out=%h", out_valid, pc_out);
    chk("t5_flush_valid", out_valid, 0);
    chk("t5_flush_pc_kept", pc_out, 32'h204);
    push(32'h000481B3, 32'h20C);
    step();
    chk("t5_x9_after_flush", rs1_data, 32'h99);

    // 6. Illegal opcode, then async reset mid-stream
    push(32'hFFFFFFFF, 32'h300);
    step();
    $display("txn illegal ill=%b rw=%b imm=%h rd=%0d", illegal, reg_write, imm, rd);
    chk("t6_illegal", illegal, 1);
    chk("t6_rw", reg_write, 0);
    chk("t6_imm", imm, 0);
    chk("t6_rd", rd, 0);
    push(32'h002081B3, 32'h304);
    step();
    chk("t6_add_rs1", rs1_data, 32'hAAAA);
    rst = 1'b1;
    #1;
    $display("txn async reset out_valid=%b pc_out=%h", out_valid, pc_out);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_pc", pc_out, 0);
    chk("t6_rst_rs1", rs1_data, 0);
    #4;
    rst = 1'b0;
    push(32'h002081B3, 32'h308);
    step();
    chk("t6_post_rst_valid", out_valid, 1);
    chk("t6_post_rst_rs1", rs1_data, 0);
    chk("t6_post_rst_rs2", rs2_data, 0);
    in_valid = 1'b0;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
